// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle PC/IR sequencing FSM (FETCH..WB, HALT).
// Optional macro PC_TRAP_EN adds a TRAP state and Trap port for unknown opcodes.
module pc_sequencer (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [31:0] PCout,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic [15:0] Imm16,
    input  logic [25:0] JIdx,
    input  logic [31:0] Rs_data,
    input  logic        IMEM_RDY,
    input  logic        DMEM_RDY,
    output logic        PC_EN,
    output logic [31:0] PCin,
    output logic        IR_EN,
    output logic [2:0]  Stage,
    output logic        Halt
`ifdef PC_TRAP_EN
    ,
    output logic        Trap
`endif
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;
`ifdef PC_TRAP_EN
    localparam logic [2:0] TRAP   = 3'd6;
    localparam logic [2:0] UNK    = TRAP;
`else
    localparam logic [2:0] UNK    = WB;
`endif

    logic [2:0]  state, state_nx;
    logic [31:0] pc4, br_tgt, j_tgt;
    logic is_beq, is_bne, is_j, is_jr, is_jal, is_lw, is_sw, is_alu, is_halt;
    logic is_known, exec_pc, taken, in_exec, in_trap;

    assign is_beq   = Op == 6'b000100;
    assign is_bne   = Op == 6'b000101;
    assign is_j     = Op == 6'b000010;
    assign is_jr    = Op == 6'b000000 && Funct == 6'b001000;
    assign is_jal   = Op == 6'b000011;
    assign is_lw    = Op == 6'b100011;
    assign is_sw    = Op == 6'b101011;
    assign is_alu   = (Op == 6'b000000 && !is_jr) || Op[5:3] == 3'b001;
    assign is_halt  = Op == 6'b111111;
    assign is_known = is_beq | is_bne | is_j | is_jr | is_jal | is_lw | is_sw | is_alu | is_halt;
    assign exec_pc  = is_beq | is_bne | is_j | is_jr;
    assign taken    = (is_beq & Zero) | (is_bne & ~Zero);

    assign pc4    = PCout + 32'd4;
    assign br_tgt = pc4 + {{14{Imm16[15]}}, Imm16, 2'b00};
    assign j_tgt  = {pc4[31:28], JIdx, 2'b00};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  state_nx = IMEM_RDY ? DECODE : FETCH;
            DECODE: state_nx = EXEC;
            EXEC:   state_nx = exec_pc ? FETCH : (is_lw | is_sw) ? MEM : is_halt ? HALT : is_known ? WB : UNK;
            MEM:    state_nx = !DMEM_RDY ? MEM : is_sw ? FETCH : WB;
            WB:     state_nx = FETCH;
            HALT:   state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    assign in_exec = state == EXEC;
`ifdef PC_TRAP_EN
    assign in_trap = state == TRAP;
    assign Trap    = in_trap;
`else
    assign in_trap = 1'b0;
`endif

    // IR_EN is gated by reset directly so it stays low even with IMEM_RDY high in reset
    assign IR_EN = RST_n & (state == FETCH) & IMEM_RDY;
    assign PC_EN = (in_exec & exec_pc) | (state == MEM & DMEM_RDY & is_sw) | (state == WB) | in_trap;
    assign PCin  = (in_exec & taken) ? br_tgt :
                   ((in_exec & is_j) | (state == WB & is_jal)) ? j_tgt :
                   (in_exec & is_jr) ? Rs_data :
                   in_trap ? 32'h0000_0180 : pc4;
    assign Stage = state;
    assign Halt  = state == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random instruction streams checked cycle by cycle
// against an instruction-level reference model (works with or without PC_TRAP_EN).
module tb_pc_sequencer;
    logic        CLK = 1'b0, RST_n = 1'b1;
    logic [31:0] PCout = '0, Rs_data = '0;
    logic [5:0]  Op = '0, Funct = '0;
    logic        Zero = 1'b0, IMEM_RDY = 1'b0, DMEM_RDY = 1'b0;
    logic [15:0] Imm16 = '0;
    logic [25:0] JIdx = '0;
    logic        PC_EN, IR_EN, Halt, Trap;
    logic [31:0] PCin;
    logic [2:0]  Stage;

    int n_vec = 0, n_bad = 0;
    logic [31:0] last_pcin, pc;

    typedef struct {
        logic imem, dmem;
        logic [2:0] stage;
        logic pc_en, ir_en, halt, trap;
        logic [31:0] pcin;
    } cyc_t;
    cyc_t q[$];

    pc_sequencer dut (
        .CLK(CLK), .RST_n(RST_n), .PCout(PCout), .Op(Op), .Funct(Funct), .Zero(Zero),
        .Imm16(Imm16), .JIdx(JIdx), .Rs_data(Rs_data), .IMEM_RDY(IMEM_RDY), .DMEM_RDY(DMEM_RDY),
        .PC_EN(PC_EN), .PCin(PCin), .IR_EN(IR_EN), .Stage(Stage), .Halt(Halt)
`ifdef PC_TRAP_EN
        , .Trap(Trap)
`endif
    );
`ifndef PC_TRAP_EN
    assign Trap = 1'b0;
`endif

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic imem, dmem, input logic [2:0] st, input logic pe, ie, h, t,
                        input logic [31:0] pci);
        cyc_t c;
        c.imem = imem; c.dmem = dmem; c.stage = st; c.pc_en = pe; c.ir_en = ie;
        c.halt = h; c.trap = t; c.pcin = pci;
        q.push_back(c);
    endtask

    // Instruction-level model: architectural next PC plus the cycle path it takes.
    task automatic plan(input logic [5:0] op, funct, input logic [15:0] imm, input logic [25:0] jidx,
                        input logic [31:0] rs, pcv, input logic zero, input int iw, mw,
                        output logic [31:0] nxt);
        logic [31:0] p4, bt, jt;
        int off;
        p4 = pcv + 32'd4;
        off = int'($signed(imm));
        bt = p4 + 32'(off * 4);
        jt = (p4 & 32'hF000_0000) | (32'(jidx) * 32'd4);
        nxt = p4;
        for (int i = 0; i < iw; i++) push(0, 0, 3'd0, 0, 0, 0, 0, p4);
        push(1, 0, 3'd0, 0, 1, 0, 0, p4);
        push(0, 0, 3'd1, 0, 0, 0, 0, p4);
        if (op == 6'h04 || op == 6'h05 || op == 6'h02 || (op == 6'h00 && funct == 6'h08)) begin
            nxt = (op == 6'h04) ? (zero ? bt : p4) : (op == 6'h05) ? (!zero ? bt : p4) :
                  (op == 6'h02) ? jt : rs;
            push(0, 0, 3'd2, 1, 0, 0, 0, nxt);
        end else if (op == 6'h03) begin
            nxt = jt;
            push(0, 0, 3'd2, 0, 0, 0, 0, p4);
            push(0, 0, 3'd4, 1, 0, 0, 0, jt);
        end else if (op == 6'h23 || op == 6'h2B) begin
            push(0, 0, 3'd2, 0, 0, 0, 0, p4);
            for (int i = 0; i < mw; i++) push(0, 0, 3'd3, 0, 0, 0, 0, p4);
            push(0, 1, 3'd3, op == 6'h2B, 0, 0, 0, p4);
            if (op == 6'h23) push(0, 0, 3'd4, 1, 0, 0, 0, p4);
        end else if (op == 6'h00 || op[5:3] == 3'b001) begin
            push(0, 0, 3'd2, 0, 0, 0, 0, p4);
            push(0, 0, 3'd4, 1, 0, 0, 0, p4);
        end else if (op == 6'h3F) begin
            push(0, 0, 3'd2, 0, 0, 0, 0, p4);
            for (int i = 0; i < 20; i++) push(1, 1, 3'd5, 0, 0, 1, 0, p4);
        end else begin
            push(0, 0, 3'd2, 0, 0, 0, 0, p4);
`ifdef PC_TRAP_EN
            nxt = 32'h0000_0180;
            push(0, 0, 3'd6, 1, 0, 0, 1, nxt);
`else
            push(0, 0, 3'd4, 1, 0, 0, 0, p4);
`endif
        end
    endtask

    // Apply up to n queued cycles (n<0: all); called at posedge+1.
    task automatic run(input int n);
        cyc_t c;
        int k;
        k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            c = q.pop_front();
            IMEM_RDY = c.imem; DMEM_RDY = c.dmem;
            #1;
            chk("stage", 32'(Stage), 32'(c.stage));
            chk("pc_en", 32'(PC_EN), 32'(c.pc_en));
            chk("ir_en", 32'(IR_EN), 32'(c.ir_en));
            chk("halt",  32'(Halt),  32'(c.halt));
            chk("trap",  32'(Trap),  32'(c.trap));
            chk("pcin",  PCin, c.pcin);
            if (PC_EN) last_pcin = PCin;
            @(posedge CLK); #1;
            k++;
        end
    endtask

    task automatic exec(input logic [5:0] op, funct, input logic [15:0] imm, input logic [25:0] jidx,
                        input logic [31:0] rs, input logic zero, input int iw, mw);
        logic [31:0] nxt;
        Op = op; Funct = funct; Imm16 = imm; JIdx = jidx; Rs_data = rs; Zero = zero; PCout = pc;
        plan(op, funct, imm, jidx, rs, pc, zero, iw, mw, nxt);
        run(-1);
        pc = nxt;
    endtask

    task automatic reset_chk(input string tag);
        q.delete();
        RST_n = 1'b0; IMEM_RDY = 1'b1; DMEM_RDY = 1'b1;
        #1;
        chk({tag, "_stage"}, 32'(Stage), 32'd0);
        chk({tag, "_pc_en"}, 32'(PC_EN), 32'd0);
        chk({tag, "_ir_en"}, 32'(IR_EN), 32'd0);
        chk({tag, "_halt"},  32'(Halt),  32'd0);
        chk({tag, "_trap"},  32'(Trap),  32'd0);
        @(posedge CLK); #1;
        chk({tag, "_stage_clk"}, 32'(Stage), 32'd0);
        chk({tag, "_ir_en_clk"}, 32'(IR_EN), 32'd0);
        RST_n = 1'b1; IMEM_RDY = 1'b0; DMEM_RDY = 1'b0;
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [31:0] nxt;
        #1;
        reset_chk("rst0");
        pc = 32'h0000_0000;
        exec(6'h08, 6'h00, 16'h0001, 26'h0, 32'h0, 1'b0, 3, 0);
        pc = 32'h0000_0010;
        exec(6'h04, 6'h00, 16'hFFFF, 26'h0, 32'h0, 1'b1, 0, 0);
        chk("beq_taken", last_pcin, 32'h0000_0010);
        pc = 32'h0000_0010;
        exec(6'h04, 6'h00, 16'hFFFF, 26'h0, 32'h0, 1'b0, 0, 0);
        chk("beq_not_taken", last_pcin, 32'h0000_0014);
        pc = 32'h1000_0008;
        exec(6'h03, 6'h00, 16'h0, 26'h000_0040, 32'h0, 1'b0, 0, 0);
        chk("jal_tgt", last_pcin, 32'h1000_0100);
        pc = 32'h0000_2000;
        exec(6'h23, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 1, 4);
        chk("lw_wb", last_pcin, 32'h0000_2004);
        pc = 32'hFFFF_FFFC;
        exec(6'h09, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);
        chk("wrap", last_pcin, 32'h0000_0000);
        pc = 32'h0000_0300;
        exec(6'h17, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);
`ifdef PC_TRAP_EN
        chk("unknown_trap", last_pcin, 32'h0000_0180);
`else
        chk("unknown_nop", last_pcin, 32'h0000_0304);
`endif
        // lw stalled in MEM, reset asserted mid-wait: abandoned with no PC update
        pc = 32'h0000_4000;
        Op = 6'h23; Funct = 6'h0; Imm16 = '0; JIdx = '0; Rs_data = '0; Zero = 1'b0; PCout = pc;
        plan(6'h23, 6'h0, 16'h0, 26'h0, 32'h0, pc, 1'b0, 0, 4, nxt);
        run(5);
        chk("pre_rst_stage", 32'(Stage), 32'd3);
        reset_chk("rst_mem");
        for (int i = 0; i < 40; i++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 9))
                0: op = 6'h04;
                1: op = 6'h05;
                2: op = 6'h02;
                3: begin op = 6'h00; fn = 6'h08; end
                4: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
                5: op = 6'h03;
                6: op = 6'h23;
                7: op = 6'h2B;
                8: op = {3'b001, 3'($urandom)};
                default: op = ($urandom_range(0, 1) == 0) ? 6'h17 : 6'h3E;
            endcase
            if ($urandom_range(0, 3) == 0) pc = $urandom & 32'hFFFF_FFFC;
            exec(op, fn, 16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 3));
        end
        pc = 32'h0000_5000;
        exec(6'h3F, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 0, 0);
        chk("halted", 32'(Halt), 32'd1);
        reset_chk("rst_halt");
        pc = 32'h0000_0000;
        exec(6'h2B, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0, 0, 2);
        chk("sw_after_halt", last_pcin, 32'h0000_0004);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: CLK in 1, state clocked on the posedge; RST_n in 1, asynchronous, active-low.
REQ-002 SHALL have the following inputs:
- PCout in 32: current value of the PC register.
- Op in 6: instruction opcode.
- Funct in 6: R-type function field.
- Zero in 1: ALU zero flag, valid in EXEC.
- Imm16 in 16: branch offset.
- JIdx in 26: jump index.
- Rs_data in 32: register rs value, used by jr.
- IMEM_RDY in 1: instruction memory data valid.
- DMEM_RDY in 1: data memory access done.
REQ-003 SHALL have the following outputs:
- PC_EN out 1: PC write enable. The PC register captures PCin on the negedge inside the same cycle.
- PCin out 32: next PC value.
- IR_EN out 1: instruction register load enable.
- Stage out 3: current state encoding.
- Halt out 1: high in HALT.
- Trap out 1: present only with PC_TRAP_EN.

Function
REQ-004 SHALL implement these states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6 (TRAP only with PC_TRAP_EN). Stage SHALL equal the state.
REQ-005 FETCH behaviour:
- IMEM_RDY=0: hold in FETCH with all enables low.
- IMEM_RDY=1: IR_EN=1 for exactly that cycle, then go to DECODE.
REQ-006 DECODE SHALL go unconditionally to EXEC after one cycle.
REQ-007 EXEC, branch on beq (Op=000100) and bne (Op=000101):
- PC_EN=1.
- PCin = PCout+4+(sext(Imm16)<<2) when taken (beq: Zero=1; bne: Zero=0), otherwise PCout+4.
- Then go to FETCH.
REQ-008 EXEC, j (Op=000010): PC_EN=1, PCin={PCout+4[31:28], JIdx, 2'b00}, then go to FETCH.
REQ-009 EXEC, jr (Op=000000, Funct=001000): PC_EN=1, PCin=Rs_data, then go to FETCH.
REQ-010 EXEC, jal (Op=000011): go to WB, no PC update in EXEC.
REQ-011 EXEC, lw (100011) and sw (101011): go to MEM.
REQ-012 EXEC, other R-type and immediate ALU ops (Op=000000 excluding jr; Op=001xxx): go to WB.
REQ-013 EXEC, Op=111111: go to HALT, no PC update.
REQ-014 MEM SHALL hold while DMEM_RDY=0.
- DMEM_RDY=1 and sw: PC_EN=1, PCin=PCout+4, then go to FETCH.
- DMEM_RDY=1 and lw: go to WB.
REQ-015 WB: PC_EN=1 for one cycle, then go to FETCH.
- jal: PCin = jump target, computed as in REQ-008.
- all other instructions: PCin=PCout+4.
REQ-016 Op, Funct and Imm16 SHALL be sampled from the instruction register. The block SHALL NOT latch the opcode itself.
REQ-017 PCin SHALL equal PCout+4 in every cycle where PC_EN=0, so it is never X or stale.
REQ-018 All PC arithmetic SHALL be 32-bit modulo 2^32; PCout=FFFF_FFFC with +4 wraps to 0000_0000.
REQ-019 PC_EN SHALL be asserted at most once per instruction and never in FETCH or DECODE.
REQ-020 HALT SHALL be absorbing: Halt=1, all enables 0, exit only by reset.
REQ-021 Unknown opcodes without PC_TRAP_EN SHALL go to WB and behave as a NOP, advancing the PC by 4.

Reset
REQ-022 While RST_n=0, regardless of CLK, outputs SHALL be: state=FETCH, PC_EN=0, IR_EN=0, Halt=0, Trap=0.
REQ-023 Reset asserted mid-MEM or mid-wait SHALL abandon the instruction with no PC update.
REQ-024 The first IR_EN after reset release SHALL occur in the first cycle with IMEM_RDY=1.

Configuration
REQ-025 Macro PC_TRAP_EN:
- Defined: an unknown opcode in EXEC goes to TRAP. TRAP asserts PC_EN=1 with PCin=32'h0000_0180 and Trap=1 for one cycle, then goes to FETCH.
- Undefined: the TRAP state, the Trap port and the trap logic are absent, and REQ-021 applies.

Verification
REQ-026 Reset, then IMEM_RDY low for 3 cycles, then high -> Stage stays 0 for 3 cycles, IR_EN pulses once, Stage=1 next.
REQ-027 PCout=0000_0010, beq, Zero=1, Imm16=FFFF -> PC_EN=1 in EXEC, PCin=0000_0010. Same with Zero=0 -> PCin=0000_0014.
REQ-028 PCout=1000_0008, jal, JIdx=000_0040 -> EXEC with PC_EN=0, then WB with PC_EN=1, PCin=1000_0100.
REQ-029 lw with DMEM_RDY low for 4 cycles -> Stage=3 held for 4 cycles, then WB, PCin=PCout+4. RST_n pulsed during the wait -> Stage=0 immediately, PC_EN never asserted.
REQ-030 Op=111111 -> Halt=1, no further PC_EN or IR_EN for 20 cycles. Unknown Op=010111 with PC_TRAP_EN -> Trap=1, PCin=0000_0180; without the macro -> PCin=PCout+4.
